// File: rtl/mp_responder.sv
// mp_responder: memory-side responder for cache line-fill reads and write-backs, valid/ready on both sides
// clock, reset        : rising-edge clock, synchronous active-high reset
// req_valid/req_ready : request handshake; req_wren, req_address, req_data describe the request
// resp_valid/resp_ready: response handshake; resp_data, resp_wren describe the response
// rd_count, wr_count  : saturating counts of completed reads and writes
module mp_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wren,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_wren,
  output logic [7:0]        rd_count,
  output logic [7:0]        wr_count
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic wren;
  // Words are stored XORed with their own address, so a zero-initialised array reads back mem[i] = i.
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] pat;
  logic accept, commit, handshake;
  always_comb begin
    pat       = DATA_W'(addr);
    accept    = state == IDLE && req_valid;
    commit    = state == ACCESS && cnt == 4'd0;
    handshake = state == RESPOND && resp_ready;
    req_ready  = state == IDLE;
    resp_valid = state == RESPOND;
    state_n = accept ? ACCESS : commit ? RESPOND : handshake ? IDLE : state;
  end
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= 4'd0;
      resp_data <= '0;
      resp_wren <= 1'b0;
      rd_count  <= 8'd0;
      wr_count  <= 8'd0;
    end else begin
      if (accept) begin
        addr <= req_address;
        data <= req_data;
        wren <= req_wren;
        cnt  <= 4'(LATENCY - 1);
      end
      if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (commit) begin
        resp_data <= wren ? data : mem[addr] ^ pat;
        resp_wren <= wren;
      end
      if (handshake && wren && wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
      if (handshake && !wren && rd_count != 8'hFF) rd_count <= rd_count + 8'd1;
    end
  end
  always_ff @(posedge clock) if (!reset && commit && wren) mem[addr] <= data ^ pat;
endmodule

// File: doc/mp_responder.md
Name: mp_responder

Overview:
- Main-memory responder: the memory-side end of the cache-to-main-memory request interface.
- Serves single-word read (line fill) and write (write-back) requests from the cache controller.
- Uses a valid/ready request handshake, a programmable access latency and a valid/ready response handshake.
- Replaces the zero-latency, manually clocked memory access with a clocked, back-pressured protocol; sits between the cache and the 256x8 storage array.

Parameters:
- ADDR_W, 8, address width; storage depth is 2**ADDR_W words.
- DATA_W, 8, data word width.
- LATENCY, 2, number of ACCESS cycles between request acceptance and response; legal range 1..15.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  cache presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_wren  input  1  1 = write (write-back), 0 = read (fill).
- req_address  input  ADDR_W  word address.
- req_data  input  DATA_W  write data; ignored on reads.
- resp_valid  output  1  response available.
- resp_ready  input  1  cache accepts the response.
- resp_data  output  DATA_W  read data, or echo of the written data on writes.
- resp_wren  output  1  copy of req_wren for the request being answered.
- rd_count  output  8  completed reads, saturating at 255.
- wr_count  output  8  completed writes, saturating at 255.

Behaviour:
- FSM states: IDLE, ACCESS, RESPOND.
- Reset (synchronous, dominant over all other inputs):
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_data = 0; resp_wren = 0; rd_count = wr_count = 0; latency counter = 0.
  - Storage array is not cleared by reset. Time-zero contents: mem[i] = i[DATA_W-1:0].
- IDLE:
  - req_ready = 1.
  - On req_valid = 1, register address, data and wren, load the latency counter with LATENCY-1, clear req_ready and go to ACCESS. Call this acceptance edge T.
  - Otherwise stay in IDLE.
- ACCESS:
  - req_ready = 0; request inputs are ignored.
  - Counter decrements each cycle.
  - At the edge where counter = 0:
    - write: mem[addr] = captured data; resp_data = captured data.
    - read: resp_data = mem[addr].
    - Set resp_valid = 1 and resp_wren; go to RESPOND.
  - resp_valid therefore first rises at edge T+LATENCY.
- RESPOND:
  - resp_valid, resp_data and resp_wren are held stable until resp_ready = 1.
  - On the handshake edge: resp_valid = 0; increment rd_count or wr_count (saturating, no wrap); req_ready = 1; go to IDLE.
- Throughput: at most one outstanding request. A new request is accepted no earlier than the edge after the response handshake, so a read after a write to the same address returns the new data.
- req_valid may be deasserted while in ACCESS or RESPOND without effect.
- Reset during ACCESS aborts the request. A write is not committed if reset arrives at or before its commit edge.
- Reset during RESPOND drops the response; a write already committed stays in memory.
- resp_ready is ignored outside RESPOND.
- Address and data widths are exact; no truncation or extension is performed.

Test Plan:
- Reset, then read addr 0x05 with LATENCY=2 and resp_ready held 1 -> resp_valid rises 2 cycles after acceptance; resp_data=0x05; resp_wren=0; rd_count=1; req_ready back to 1 the next cycle.
- Write 0x3C to addr 0x02, then read addr 0x02 -> write response echoes 0x3C with resp_wren=1; read returns 0x3C; wr_count=1, rd_count=1.
- Back-pressure: read addr 0x07 with resp_ready=0 for 5 cycles -> resp_valid and resp_data=0x07 held stable; req_ready=0 throughout; a competing req_valid during this time is not accepted; completes on the first resp_ready=1.
- Reset mid-write: write 0xAA to addr 0x10, assert reset during ACCESS, then read addr 0x10 -> returns 0x10 (write aborted); both counters = 0 after reset.
- Saturation: 260 back-to-back reads -> rd_count stops at 255; wr_count stays 0.
- LATENCY=1 build: read addr 0xFF -> resp_valid at the edge after acceptance; resp_data=0xFF.
